hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the dual-issue five-stage core, parametrised in issue width, register-address width and divider latency. It detects load-use hazards across all issue slots (register 0 exempt), owns the multi-cycle divider stall FSM and its start handshake, and gives exceptions priority over branches and stalls. It also keeps saturating stall and flush performance counters. It sits beside the stage registers and drives every per-stage enable and flush.

## Interface
Parameters:
- NISSUE, 2, issue slots per stage (slot 0 = master)
- RADDR_W, 5, register address width
- DIV_CYCLES, 34, divider stall cycles per divide (≥1)
- CNT_W, 32, performance counter width

Ports (stage index: 0=F, 1=D, 2=E, 3=M, 4=W):
- clk  in  1  clock; everything rising-edge
- resetn  in  1  asynchronous, active-low reset
- D_rs, D_rt  in  NISSUE*RADDR_W  D-stage source registers, slot i at [i*RADDR_W +: RADDR_W]
- E_memtoReg, M_memtoReg  in  NISSUE  per-slot load in E / M
- E_reg_waddr, M_reg_waddr  in  NISSUE*RADDR_W  per-slot destinations
- E_branch_taken  in  1  branch in E resolved taken
- E_div_req  in  1  divide instruction occupies E
- M_exception  in  1  exception committed in M
- stage_ena  out  5  stage register enables
- stage_flush  out  5  stage register flushes; flush beats enable
- div_start  out  1  one-cycle start pulse to divider
- div_done  out  1  divider result capture cycle
- stall_cycles  out  CNT_W  cycles with stage_ena[0]=0
- flush_events  out  CNT_W  cycles with M_exception=1

## Operation
- Load-use: lwstall = OR over D slot i, source s∈{rs,rt}, s≠0, producer slot j: (E_memtoReg[j] & s==E_reg_waddr[j]) | (M_memtoReg[j] & s==M_reg_waddr[j]). lwstall_eff = lwstall & ~E_branch_taken & ~M_exception.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE & E_div_req & ~M_exception: div_start=1, div_stall=1, cnt←DIV_CYCLES-1, go to BUSY. If DIV_CYCLES==1, go to DONE instead.
  - BUSY: div_stall=1, cnt←cnt-1; cnt==1 → DONE.
  - DONE: div_stall=0, div_done=1, always → IDLE.
  - M_exception in any state: div_stall=0 that same cycle; next state IDLE; cnt←0.
- Enables: stage_ena[0]=stage_ena[1]=~(lwstall_eff|div_stall); stage_ena[2]=stage_ena[3]=~div_stall; stage_ena[4]=1.
- Flushes, priority exception > branch > stall:
  - M_exception: flush[3:0]=4'b1111, flush[4]=0.
  - else E_branch_taken & ~div_stall: flush[1]=1, flush[2]=1.
  - else lwstall_eff & ~div_stall: flush[2]=1 (bubble into E).
  - Otherwise all flush bits are 0.
- Counters: increment by one per qualifying cycle and saturate at all-ones; never wrap.

## Timing
- Enables, flushes, div_start and div_done are combinational from inputs and registered state, with zero latency.
- A divide with no exception stalls E/M for exactly DIV_CYCLES cycles. div_done asserts in the following cycle, and E advances in that cycle.
- Back-to-back divides: after DONE, IDLE sees the new E_div_req and restarts. No idle cycle is inserted beyond DONE.
- Reset (asynchronous, mid-divide included): state=IDLE, cnt=0, both counters=0.
- Outputs during reset: stage_ena=5'b11111 when inputs are idle, stage_flush=0, div_start=0, div_done=0.
- Simultaneous E_branch_taken and div_stall: no flush. The branch holds in E and flushes on the release cycle (DONE).

## Structure
- hazard_pkg: div state enum (IDLE/BUSY/DONE), stage index constants STG_F..STG_W, NSTAGE=5.
- Sub-module div_stall_fsm (state, counter, div_start, div_done, div_stall). hazard_ctrl holds the comparators, priority logic and counters.

## Test plan
- Slot1 D_rs=5'd8, E_memtoReg[0]=1, E_reg_waddr slot0=8 → stage_ena=5'b11100, stage_flush=5'b00100, stall_cycles +1.
- D_rt=0 and E load to r0 → no stall; stage_ena=5'b11111.
- DIV_CYCLES=4, E_div_req held → div_start at t0 only; stage_ena[3:0]=0 for t0..t3; div_done=1 and all enables 1 at t4.
- M_exception at t2 of a divide → same cycle stage_flush=5'b01111, stage_ena=5'b11111; FSM IDLE at t3; no div_done.
- E_branch_taken with lwstall → stage_flush=5'b00110, stage_ena=5'b11111. Branch during BUSY → flush withheld until DONE.
- CNT_W=4, 20 consecutive stall cycles → stall_cycles saturates at 4'hF; resetn low mid-divide → counters 0, state IDLE.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int STG_F  = 0;
  localparam int STG_D  = 1;
  localparam int STG_E  = 2;
  localparam int STG_M  = 3;
  localparam int STG_W  = 4;
  localparam int NSTAGE = 5;

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divider stall sequencer: start pulse, stall window, done cycle.
// An exception in M kills any divide in flight and releases the stall at once.
module div_stall_fsm
  import hazard_pkg::*;
#(
  parameter int DIV_CYCLES = 34
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_div_req,
  input  logic i_exception,
  output logic o_div_start,
  output logic o_div_done,
  output logic o_div_stall
);

  // Counter must hold DIV_CYCLES-1; +1 keeps width >= 1 when DIV_CYCLES == 1.
  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  // State and countdown registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and outputs. The start cycle itself counts as the first stall
  // cycle, so BUSY covers the remaining DIV_CYCLES-1 cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_div_start = 1'b0;
    o_div_done  = 1'b0;
    o_div_stall = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_div_req && !i_exception) begin
          o_div_start = 1'b1;
          o_div_stall = 1'b1;
          w_cnt_nxt   = CW'(DIV_CYCLES - 1);
          w_state_nxt = (DIV_CYCLES == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        o_div_stall = 1'b1;
        w_cnt_nxt   = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        o_div_done  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_exception) begin
      o_div_stall = 1'b0;
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller: load-use detection across all issue slots,
// divider stall sequencing, prioritised flushes and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NISSUE     = 2,
  parameter int RADDR_W    = 5,
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W      = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NISSUE*RADDR_W-1:0] D_rs,
  input  logic [NISSUE*RADDR_W-1:0] D_rt,
  input  logic [NISSUE-1:0]         E_memtoReg,
  input  logic [NISSUE-1:0]         M_memtoReg,
  input  logic [NISSUE*RADDR_W-1:0] E_reg_waddr,
  input  logic [NISSUE*RADDR_W-1:0] M_reg_waddr,
  input  logic                      E_branch_taken,
  input  logic                      E_div_req,
  input  logic                      M_exception,
  output logic [NSTAGE-1:0]         stage_ena,
  output logic [NSTAGE-1:0]         stage_flush,
  output logic                      div_start,
  output logic                      div_done,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          flush_events
);

  logic w_lwstall, w_lwstall_eff, w_div_stall;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_events;

  // A source hits when it is non-zero and matches a load destination in E or M.
  function automatic logic f_src_hit(input logic [RADDR_W-1:0] s, input int j);
    logic hit;
    hit = (E_memtoReg[j] && (s == E_reg_waddr[j*RADDR_W +: RADDR_W])) ||
          (M_memtoReg[j] && (s == M_reg_waddr[j*RADDR_W +: RADDR_W]));
    return (s != '0) && hit;
  endfunction

  div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk         (clk),
    .resetn      (resetn),
    .i_div_req   (E_div_req),
    .i_exception (M_exception),
    .o_div_start (div_start),
    .o_div_done  (div_done),
    .o_div_stall (w_div_stall)
  );

  // Load-use compare of every D source against every E/M producer slot.
  always_comb begin
    w_lwstall = 1'b0;
    for (int i = 0; i < NISSUE; i++) begin
      for (int j = 0; j < NISSUE; j++) begin
        if (f_src_hit(D_rs[i*RADDR_W +: RADDR_W], j) ||
            f_src_hit(D_rt[i*RADDR_W +: RADDR_W], j))
          w_lwstall = 1'b1;
      end
    end
  end

  // A taken branch or exception discards the dependent instruction anyway.
  assign w_lwstall_eff = w_lwstall && !E_branch_taken && !M_exception;

  // Enables and flushes; exception > branch > load-use bubble. While the
  // divider stalls, branch and bubble flushes wait for the release cycle.
  always_comb begin
    stage_ena          = '1;
    stage_ena[STG_F]   = !(w_lwstall_eff || w_div_stall);
    stage_ena[STG_D]   = !(w_lwstall_eff || w_div_stall);
    stage_ena[STG_E]   = !w_div_stall;
    stage_ena[STG_M]   = !w_div_stall;
    stage_flush        = '0;
    if (M_exception) begin
      stage_flush[STG_F] = 1'b1;
      stage_flush[STG_D] = 1'b1;
      stage_flush[STG_E] = 1'b1;
      stage_flush[STG_M] = 1'b1;
    end else if (E_branch_taken && !w_div_stall) begin
      stage_flush[STG_D] = 1'b1;
      stage_flush[STG_E] = 1'b1;
    end else if (w_lwstall_eff && !w_div_stall) begin
      stage_flush[STG_E] = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!stage_ena[STG_F] && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (M_exception && (r_flush_events != '1))
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (2 slots, 5-bit regs, 4-cycle divide, 4-bit counters).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [9:0] D_rs, D_rt, E_reg_waddr, M_reg_waddr;
  logic [1:0] E_memtoReg, M_memtoReg;
  logic       E_branch_taken, E_div_req, M_exception;
  logic [4:0] stage_ena, stage_flush;
  logic       div_start, div_done;
  logic [3:0] stall_cycles, flush_events;

  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  hazard_ctrl #(.NISSUE(2), .RADDR_W(5), .DIV_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .D_rs(D_rs), .D_rt(D_rt),
    .E_memtoReg(E_memtoReg), .M_memtoReg(M_memtoReg),
    .E_reg_waddr(E_reg_waddr), .M_reg_waddr(M_reg_waddr),
    .E_branch_taken(E_branch_taken), .E_div_req(E_div_req), .M_exception(M_exception),
    .stage_ena(stage_ena), .stage_flush(stage_flush),
    .div_start(div_start), .div_done(div_done),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic set_idle();
    D_rs = '0; D_rt = '0; E_reg_waddr = '0; M_reg_waddr = '0;
    E_memtoReg = '0; M_memtoReg = '0;
    E_branch_taken = 1'b0; E_div_req = 1'b0; M_exception = 1'b0;
  endtask

  // Slot1 rs = r8 while slot0 in E loads r8.
  task automatic set_lu();
    set_idle();
    D_rs[9:5] = 5'd8; E_memtoReg = 2'b01; E_reg_waddr[4:0] = 5'd8;
  endtask

  // Advance one cycle; the bench's own counter model is updated from what it drove.
  task automatic tick(input bit stalled);
    if (stalled && exp_stall < 15) exp_stall++;
    if (M_exception && exp_flush < 15) exp_flush++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL rst_ena got %b exp 11111", stage_ena); end
    n_vec++; if (stage_flush !== 5'b00000) begin n_err++; $display("FAIL rst_flush got %b exp 00000", stage_flush); end
    n_vec++; if (div_start !== 1'b0) begin n_err++; $display("FAIL rst_start got %b exp 0", div_start); end
    n_vec++; if (div_done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", div_done); end
    n_vec++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL rst_stallcnt got %0d exp 0", stall_cycles); end
    n_vec++; if (flush_events !== 4'd0) begin n_err++; $display("FAIL rst_flushcnt got %0d exp 0", flush_events); end
  endtask

  task automatic test_load_use();
    set_lu(); #1;
    n_vec++; if (stage_ena !== 5'b11100) begin n_err++; $display("FAIL lu_e_ena got %b exp 11100", stage_ena); end
    n_vec++; if (stage_flush !== 5'b00100) begin n_err++; $display("FAIL lu_e_flush got %b exp 00100", stage_flush); end
    tick(1);
    n_vec++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lu_e_cnt got %0d exp 1", stall_cycles); end
    // Slot0 rt = r9 while slot1 in M loads r9.
    set_idle(); D_rt[4:0] = 5'd9; M_memtoReg = 2'b10; M_reg_waddr[9:5] = 5'd9; #1;
    n_vec++; if (stage_ena !== 5'b11100) begin n_err++; $display("FAIL lu_m_ena got %b exp 11100", stage_ena); end
    n_vec++; if (stage_flush !== 5'b00100) begin n_err++; $display("FAIL lu_m_flush got %b exp 00100", stage_flush); end
    tick(1);
    n_vec++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL lu_m_cnt got %0d exp 2", stall_cycles); end
    // Same register match but producer is not a load.
    set_idle(); D_rs[4:0] = 5'd8; E_reg_waddr[4:0] = 5'd8; #1;
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL lu_noload_ena got %b exp 11111", stage_ena); end
    tick(0);
  endtask

  task automatic test_r0();
    set_idle(); E_memtoReg = 2'b11; M_memtoReg = 2'b11; #1;
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL r0_ena got %b exp 11111", stage_ena); end
    n_vec++; if (stage_flush !== 5'b00000) begin n_err++; $display("FAIL r0_flush got %b exp 00000", stage_flush); end
    tick(0);
    n_vec++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL r0_cnt got %0d exp 2", stall_cycles); end
    set_idle();
  endtask

  task automatic test_div();
    set_idle(); E_div_req = 1'b1; #1;
    for (int t = 0; t < 4; t++) begin
      n_vec++; if (div_start !== (t == 0)) begin n_err++; $display("FAIL div_start_t%0d got %b exp %b", t, div_start, (t == 0)); end
      n_vec++; if (stage_ena !== 5'b10000) begin n_err++; $display("FAIL div_ena_t%0d got %b exp 10000", t, stage_ena); end
      n_vec++; if (div_done !== 1'b0) begin n_err++; $display("FAIL div_done_t%0d got %b exp 0", t, div_done); end
      tick(1);
    end
    n_vec++; if (div_done !== 1'b1) begin n_err++; $display("FAIL div_done_t4 got %b exp 1", div_done); end
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL div_ena_t4 got %b exp 11111", stage_ena); end
    n_vec++; if (div_start !== 1'b0) begin n_err++; $display("FAIL div_start_t4 got %b exp 0", div_start); end
    E_div_req = 1'b0; tick(0);
    n_vec++; if (div_done !== 1'b0) begin n_err++; $display("FAIL div_done_t5 got %b exp 0", div_done); end
    n_vec++; if (stall_cycles !== 4'd6) begin n_err++; $display("FAIL div_cnt got %0d exp 6", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    set_idle(); E_div_req = 1'b1; #1;
    repeat (4) tick(1);
    n_vec++; if (div_done !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b exp 1", div_done); end
    tick(0);
    n_vec++; if (div_start !== 1'b1) begin n_err++; $display("FAIL b2b_restart got %b exp 1", div_start); end
    n_vec++; if (stage_ena !== 5'b10000) begin n_err++; $display("FAIL b2b_ena got %b exp 10000", stage_ena); end
    tick(1);
    E_div_req = 1'b0; M_exception = 1'b1; #1;
    n_vec++; if (stage_flush !== 5'b01111) begin n_err++; $display("FAIL b2b_abort_flush got %b exp 01111", stage_flush); end
    tick(0);
    set_idle();
  endtask

  task automatic test_exception();
    set_idle(); E_div_req = 1'b1; #1;
    tick(1); tick(1);
    M_exception = 1'b1; #1;
    n_vec++; if (stage_flush !== 5'b01111) begin n_err++; $display("FAIL exc_flush got %b exp 01111", stage_flush); end
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL exc_ena got %b exp 11111", stage_ena); end
    n_vec++; if (div_start !== 1'b0) begin n_err++; $display("FAIL exc_start got %b exp 0", div_start); end
    tick(0);
    M_exception = 1'b0; #1;
    n_vec++; if (div_start !== 1'b1) begin n_err++; $display("FAIL exc_idle_t3 got %b exp 1", div_start); end
    n_vec++; if (div_done !== 1'b0) begin n_err++; $display("FAIL exc_done_t3 got %b exp 0", div_done); end
    tick(1);
    E_div_req = 1'b0; M_exception = 1'b1; tick(0);
    set_idle(); #1;
    n_vec++; if (flush_events !== 4'd3) begin n_err++; $display("FAIL exc_cnt got %0d exp 3", flush_events); end
  endtask

  task automatic test_branch();
    set_lu(); E_branch_taken = 1'b1; #1;
    n_vec++; if (stage_flush !== 5'b00110) begin n_err++; $display("FAIL br_lu_flush got %b exp 00110", stage_flush); end
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL br_lu_ena got %b exp 11111", stage_ena); end
    tick(0);
    set_idle(); E_div_req = 1'b1; #1;
    tick(1);
    E_branch_taken = 1'b1; #1;
    n_vec++; if (stage_flush !== 5'b00000) begin n_err++; $display("FAIL br_busy_flush got %b exp 00000", stage_flush); end
    n_vec++; if (stage_ena !== 5'b10000) begin n_err++; $display("FAIL br_busy_ena got %b exp 10000", stage_ena); end
    tick(1); tick(1);
    n_vec++; if (stage_flush !== 5'b00000) begin n_err++; $display("FAIL br_busy_t3_flush got %b exp 00000", stage_flush); end
    tick(1);
    n_vec++; if (stage_flush !== 5'b00110) begin n_err++; $display("FAIL br_done_flush got %b exp 00110", stage_flush); end
    n_vec++; if (div_done !== 1'b1) begin n_err++; $display("FAIL br_done got %b exp 1", div_done); end
    E_div_req = 1'b0; E_branch_taken = 1'b0; tick(0);
  endtask

  task automatic test_saturate();
    set_lu(); #1;
    repeat (20) tick(1);
    n_vec++; if (stall_cycles !== 4'hF) begin n_err++; $display("FAIL sat_stall got %h exp F", stall_cycles); end
    n_vec++; if (stall_cycles !== 4'(exp_stall)) begin n_err++; $display("FAIL sat_stall_model got %0d exp %0d", stall_cycles, exp_stall); end
    set_idle(); M_exception = 1'b1; #1;
    repeat (16) tick(0);
    n_vec++; if (flush_events !== 4'hF) begin n_err++; $display("FAIL sat_flush got %h exp F", flush_events); end
    set_idle(); #1;
  endtask

  task automatic test_reset_mid_div();
    set_idle(); E_div_req = 1'b1; #1;
    tick(1); tick(1);
    #2 resetn = 1'b0; E_div_req = 1'b0; #1;
    exp_stall = 0; exp_flush = 0;
    n_vec++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL mrst_stallcnt got %0d exp 0", stall_cycles); end
    n_vec++; if (flush_events !== 4'd0) begin n_err++; $display("FAIL mrst_flushcnt got %0d exp 0", flush_events); end
    n_vec++; if (stage_ena !== 5'b11111) begin n_err++; $display("FAIL mrst_ena got %b exp 11111", stage_ena); end
    n_vec++; if (div_done !== 1'b0) begin n_err++; $display("FAIL mrst_done got %b exp 0", div_done); end
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    E_div_req = 1'b1; #1;
    n_vec++; if (div_start !== 1'b1) begin n_err++; $display("FAIL mrst_idle got %b exp 1", div_start); end
    n_vec++; if (stage_ena !== 5'b10000) begin n_err++; $display("FAIL mrst_ena2 got %b exp 10000", stage_ena); end
    tick(1);
    E_div_req = 1'b0; M_exception = 1'b1; tick(0);
    set_idle(); #1;
    n_vec++; if (stall_cycles !== 4'(exp_stall)) begin n_err++; $display("FAIL mrst_cnt_after got %0d exp %0d", stall_cycles, exp_stall); end
  endtask

  initial begin
    set_idle();
    resetn = 1'b0;
    #12;
    test_reset();
    resetn = 1'b1;
    @(posedge clk); #1;
    test_load_use();
    test_r0();
    test_div();
    test_back_to_back();
    test_exception();
    test_branch();
    test_saturate();
    test_reset_mid_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
